// File: rtl/tt_pkg.sv
// Shared types and line-geometry helpers for the N x N, K-in-a-row scanner.
// line_cell maps (line index, position) to a flat cell index.
package tt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PX    = 2'b01,
    PO    = 2'b10,
    INV   = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int num_lines(input int n, input int k);
    int m;
    m = n - k + 1;
    return 2 * n * m + 2 * m * m;
  endfunction

  // Order: rows, columns, down-right, then down-left diagonals.
  function automatic int line_cell(
    input int n,
    input int k,
    input int idx,
    input int j
  );
    int m;
    int h;
    int d;
    int t;
    int r;
    int c;
    m = n - k + 1;
    h = n * m;
    d = m * m;
    if (idx < h) begin
      r = idx / m;
      c = idx % m + j;
    end else if (idx < 2 * h) begin
      t = idx - h;
      c = t / m;
      r = t % m + j;
    end else if (idx < 2 * h + d) begin
      t = idx - 2 * h;
      r = t / m + j;
      c = t % m + j;
    end else begin
      t = idx - 2 * h - d;
      r = t / m + j;
      c = k - 1 + t % m - j;
    end
    return r * n + c;
  endfunction

endpackage

// File: rtl/tt_line_check.sv
// Combinational check of one K-cell line.
// Wins only when all cells equal and hold a player mark.
module tt_line_check
  import tt_pkg::*;
#(
  parameter int K = 3
) (
  input  cell_t       i_cells [K],
  output logic        o_win,
  output logic [1:0]  o_who
);

  always_comb begin
    o_win = (i_cells[0] == PX) || (i_cells[0] == PO);
    for (int k = 1; k < K; k++) begin
      if (i_cells[k] != i_cells[0]) o_win = 1'b0;
    end
    o_who = o_win ? i_cells[0] : 2'b00;
  end

endmodule

// File: rtl/winner_scanner.sv
// Sequential win/draw scanner: snapshots the board on start and
// checks one candidate line per clock, reporting the first winner.
module winner_scanner
  import tt_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int K     = 3,
  localparam int LINES = num_lines(N, K),
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              winner,
  output logic [1:0]        who,
  output logic [LW-1:0]     win_line,
  output logic              draw
);

  localparam int NL2 = 1 << LW;

  state_t            r_state;
  logic [2*N*N-1:0]  r_snap;
  logic [LW-1:0]     r_line_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_winner;
  logic [1:0]        r_who;
  logic [LW-1:0]     r_win_line;
  logic              r_draw;

  logic [2*K-1:0]    w_lines [NL2];
  logic [2*K-1:0]    w_sel;
  cell_t             w_cells [K];
  logic              w_win;
  logic [1:0]        w_who;
  logic              w_full;
  logic              w_last;

  // Static wiring of every line onto the snapshot; pad unused slots.
  for (genvar l = 0; l < NL2; l++) begin : g_line
    if (l < LINES) begin : g_used
      for (genvar k = 0; k < K; k++) begin : g_cell
        localparam int C = line_cell(N, K, l, k);
        assign w_lines[l][2*k+:2] = r_snap[2*C+:2];
      end
    end else begin : g_pad
      assign w_lines[l] = '0;
    end
  end

  assign w_sel = w_lines[r_line_idx];

  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_cells[k] = cell_t'(w_sel[2*k+:2]);
    end
  end

  tt_line_check #(
    .K (K)
  ) u_check (
    .i_cells (w_cells),
    .o_win   (w_win),
    .o_who   (w_who)
  );

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < N * N; i++) begin
      if (r_snap[2*i+:2] == EMPTY || r_snap[2*i+:2] == INV) begin
        w_full = 1'b0;
      end
    end
  end

  assign w_last = (r_line_idx == LW'(LINES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_line_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_winner   <= 1'b0;
      r_who      <= 2'b00;
      r_win_line <= '0;
      r_draw     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_snap     <= board;
            r_line_idx <= '0;
            r_busy     <= 1'b1;
            r_winner   <= 1'b0;
            r_who      <= 2'b00;
            r_win_line <= '0;
            r_draw     <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_win) begin
            r_winner   <= 1'b1;
            r_who      <= w_who;
            r_win_line <= r_line_idx;
            r_draw     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else if (w_last) begin
            r_winner   <= 1'b0;
            r_who      <= 2'b00;
            r_win_line <= '0;
            r_draw     <= w_full;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_line_idx <= r_line_idx + LW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign winner   = r_winner;
  assign who      = r_who;
  assign win_line = r_win_line;
  assign draw     = r_draw;

endmodule

// File: tb/tb_winner_scanner.sv
// Scoreboard bench for winner_scanner: a 3x3/K=3 and a 5x5/K=4 instance
// checked against a geometric reference model of the board.
module tb_winner_scanner;

  typedef struct {
    bit         win;
    logic [1:0] who;
    int         line;
    bit         draw;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  logic        a_start = 1'b0;
  logic [17:0] a_board = '0;
  logic        a_busy, a_done, a_winner, a_draw;
  logic [1:0]  a_who;
  logic [2:0]  a_line;

  logic        b_start = 1'b0;
  logic [49:0] b_board = '0;
  logic        b_busy, b_done, b_winner, b_draw;
  logic [1:0]  b_who;
  logic [4:0]  b_line;

  exp_t qa[$];
  exp_t qb[$];

  winner_scanner #(.N(3), .K(3)) ua (
    .clock    (clk),
    .reset    (rst),
    .start    (a_start),
    .board    (a_board),
    .busy     (a_busy),
    .done     (a_done),
    .winner   (a_winner),
    .who      (a_who),
    .win_line (a_line),
    .draw     (a_draw)
  );

  winner_scanner #(.N(5), .K(4)) ub (
    .clock    (clk),
    .reset    (rst),
    .start    (b_start),
    .board    (b_board),
    .busy     (b_busy),
    .done     (b_done),
    .winner   (b_winner),
    .who      (b_who),
    .win_line (b_line),
    .draw     (b_draw)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] cell_at(input int n, input logic [127:0] b,
                                         input int r, input int c);
    return b[2*(r*n+c)+:2];
  endfunction

  // Owner of the k-long run starting at (r0,c0) stepping (dr,dc), or 00.
  function automatic logic [1:0] run_owner(input int n, input int k,
      input logic [127:0] b, input int r0, input int c0,
      input int dr, input int dc);
    logic [1:0] f;
    f = cell_at(n, b, r0, c0);
    if (f != 2'b01 && f != 2'b10) return 2'b00;
    for (int i = 1; i < k; i++)
      if (cell_at(n, b, r0 + i*dr, c0 + i*dc) != f) return 2'b00;
    return f;
  endfunction

  function automatic exp_t model(input int n, input int k,
                                 input logic [127:0] b);
    exp_t e;
    int m;
    int idx;
    logic [1:0] o;
    m = n - k + 1;
    idx = 0;
    e.win = 0; e.who = 2'b00; e.line = 0; e.draw = 0;
    for (int r = 0; r < n; r++)
      for (int s = 0; s < m; s++) begin
        o = run_owner(n, k, b, r, s, 0, 1);
        if (!e.win && o != 0) begin e.win = 1; e.who = o; e.line = idx; end
        idx++;
      end
    for (int c = 0; c < n; c++)
      for (int s = 0; s < m; s++) begin
        o = run_owner(n, k, b, s, c, 1, 0);
        if (!e.win && o != 0) begin e.win = 1; e.who = o; e.line = idx; end
        idx++;
      end
    for (int r = 0; r < m; r++)
      for (int c = 0; c < m; c++) begin
        o = run_owner(n, k, b, r, c, 1, 1);
        if (!e.win && o != 0) begin e.win = 1; e.who = o; e.line = idx; end
        idx++;
      end
    for (int r = 0; r < m; r++)
      for (int c = k - 1; c < n; c++) begin
        o = run_owner(n, k, b, r, c, 1, -1);
        if (!e.win && o != 0) begin e.win = 1; e.who = o; e.line = idx; end
        idx++;
      end
    if (!e.win) begin
      e.draw = 1;
      for (int i = 0; i < n*n; i++)
        if (b[2*i+:2] == 2'b00 || b[2*i+:2] == 2'b11) e.draw = 0;
    end
    e.cyc = e.win ? e.line + 2 : idx + 1;
    return e;
  endfunction

  function automatic logic [127:0] put(input logic [127:0] b, input int i,
                                       input logic [1:0] v);
    logic [127:0] t;
    t = b;
    t[2*i+:2] = v;
    return t;
  endfunction

  function automatic logic [127:0] rnd_board(input int cells, input int emp);
    logic [127:0] t;
    int v;
    t = '0;
    for (int i = 0; i < cells; i++) begin
      v = $urandom_range(0, 9);
      if (v < emp) t[2*i+:2] = 2'b00;
      else if (v == 9) t[2*i+:2] = 2'b11;
      else t[2*i+:2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    end
    return t;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_done) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done actual=1 required=0");
      end else begin
        e = qa.pop_front();
        chk("a_winner", 32'(a_winner), 32'(e.win));
        chk("a_who", 32'(a_who), 32'(e.who));
        chk("a_win_line", 32'(a_line), 32'(e.line));
        chk("a_draw", 32'(a_draw), 32'(e.draw));
        chk("a_latency", 32'(cyc), 32'(e.cyc));
        chk("a_busy_at_done", 32'(a_busy), 32'd0);
      end
    end
    if (b_done) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done actual=1 required=0");
      end else begin
        e = qb.pop_front();
        chk("b_winner", 32'(b_winner), 32'(e.win));
        chk("b_who", 32'(b_who), 32'(e.who));
        chk("b_win_line", 32'(b_line), 32'(e.line));
        chk("b_draw", 32'(b_draw), 32'(e.draw));
        chk("b_latency", 32'(cyc), 32'(e.cyc));
        chk("b_busy_at_done", 32'(b_busy), 32'd0);
      end
    end
  end

  // Issue one scan; caller is at a negedge. Latency is in edges from start.
  task automatic scan(input bit sel, input logic [127:0] b,
                      input bit hold, input bit perturb);
    exp_t e;
    int n;
    n = 0;
    if (!sel) begin
      e = model(3, 3, b);
      e.cyc = cyc + e.cyc;
      a_board = b[17:0];
      a_start = 1'b1;
      qa.push_back(e);
      do begin
        @(negedge clk); #1;
        if (!hold) a_start = 1'b0;
        if (perturb) a_board = 18'($urandom);
        n++;
      end while (qa.size() != 0 && n < 100);
      a_start = 1'b0;
      if (qa.size() != 0) begin
        total++; bad++;
        $display("FAIL a_timeout actual=no_done required=done");
        qa.delete();
      end
    end else begin
      e = model(5, 4, b);
      e.cyc = cyc + e.cyc;
      b_board = b[49:0];
      b_start = 1'b1;
      qb.push_back(e);
      do begin
        @(negedge clk); #1;
        if (!hold) b_start = 1'b0;
        if (perturb) b_board = 50'({$urandom, $urandom});
        n++;
      end while (qb.size() != 0 && n < 100);
      b_start = 1'b0;
      if (qb.size() != 0) begin
        total++; bad++;
        $display("FAIL b_timeout actual=no_done required=done");
        qb.delete();
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] b;
    int busy_cnt;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_winner", 32'(a_winner), 0);
    chk("rst_a_who", 32'(a_who), 0);
    chk("rst_a_line", 32'(a_line), 0);
    chk("rst_a_draw", 32'(a_draw), 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    chk("rst_b_winner", 32'(b_winner), 0);
    #1;

    // Empty board: busy for all 8 lines.
    a_board = '0;
    a_start = 1'b1;
    busy_cnt = 0;
    qa.push_back('{0, 2'b00, 0, 0, cyc + 9});
    @(negedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 20 && qa.size() != 0; i++) begin
      if (a_busy) busy_cnt++;
      @(negedge clk); #1;
    end
    chk("a_busy_cycles", 32'(busy_cnt), 8);
    repeat (2) @(negedge clk);
    #1;

    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 1, 2'b01); b = put(b, 2, 2'b01);
    b = put(b, 6, 2'b10); b = put(b, 7, 2'b10); b = put(b, 8, 2'b10);
    scan(0, b, 0, 0);

    b = '0;
    b = put(b, 2, 2'b10); b = put(b, 4, 2'b10); b = put(b, 6, 2'b10);
    scan(0, b, 0, 0);

    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 1, 2'b10); b = put(b, 2, 2'b01);
    b = put(b, 3, 2'b01); b = put(b, 4, 2'b10); b = put(b, 5, 2'b10);
    b = put(b, 6, 2'b10); b = put(b, 7, 2'b01); b = put(b, 8, 2'b01);
    scan(0, b, 0, 0);
    b = put(b, 8, 2'b11);
    scan(0, b, 0, 0);

    // Start held high through the whole scan.
    scan(0, rnd_board(9, 3), 1, 0);
    repeat (12) @(negedge clk);
    #1;
    // Board scrambled every cycle mid-scan.
    scan(0, 128'h0, 0, 1);
    scan(1, rnd_board(25, 2), 0, 1);

    // Reset in the middle of a scan: no done may follow.
    a_board = '0;
    a_start = 1'b1;
    @(negedge clk); #1;
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_done", 32'(a_done), 0);
    chk("mid_rst_winner", 32'(a_winner), 0);
    chk("mid_rst_who", 32'(a_who), 0);
    chk("mid_rst_line", 32'(a_line), 0);
    chk("mid_rst_draw", 32'(a_draw), 0);
    repeat (12) @(negedge clk);
    #1;

    b = '0;
    b = put(b, 6, 2'b01); b = put(b, 12, 2'b01);
    b = put(b, 18, 2'b01); b = put(b, 24, 2'b01);
    scan(1, b, 0, 0);
    chk("b_line23_held", 32'(b_line), 23);

    for (int i = 0; i < 30; i++) scan(0, rnd_board(9, 3), 0, 0);
    for (int i = 0; i < 30; i++)
      scan(1, rnd_board(25, (i % 3 == 0) ? 0 : 1), 0, 0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
